// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_scoreboard : in-flight write tracker driving load-use stalls, operand
//                   forward selects, halt/drain status and a stall counter.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int REG_W    = 3,
  parameter int LOAD_RDY = 1,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNT_W    = 16,
  localparam int FSEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic              iss_load,
  input  logic [REG_W-1:0]  iss_rd,
  input  logic [REG_W-1:0]  iss_rs,
  input  logic [REG_W-1:0]  iss_rt,
  input  logic              iss_use_rs,
  input  logic              iss_use_rt,
  input  logic              iss_halt,
  input  logic              flush,
  output logic              stall,
  output logic [FSEL_W-1:0] fwd_a,
  output logic [FSEL_W-1:0] fwd_b,
  output logic              halted,
  output logic              drained,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err
);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_ld;
  logic [REG_W-1:0] r_rd [DEPTH];
  logic             r_halted;
  logic             r_drained;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic              w_use_a;
  logic              w_use_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic [FSEL_W-1:0] w_fwd_a;
  logic [FSEL_W-1:0] w_fwd_b;
  logic              w_stall_req;
  logic              w_stall;
  logic              w_issue;

  assign w_use_a = iss_valid && iss_use_rs && !(ZERO_REG && (iss_rs == '0));
  assign w_use_b = iss_valid && iss_use_rt && !(ZERO_REG && (iss_rt == '0));

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_use_a && r_v[k] && (r_rd[k] == iss_rs)) begin
        w_fwd_a = FSEL_W'(k + 1);
        w_haz_a = r_ld[k] && (k < LOAD_RDY);
      end
      if (w_use_b && r_v[k] && (r_rd[k] == iss_rt)) begin
        w_fwd_b = FSEL_W'(k + 1);
        w_haz_b = r_ld[k] && (k < LOAD_RDY);
      end
    end
  end

  // The unmasked request is kept separately so a flush colliding with it can be flagged.
  assign w_stall_req = (w_haz_a || w_haz_b) && !r_halted;
  assign w_stall     = w_stall_req && !flush;
  assign w_issue     = iss_valid && iss_we && !w_stall && !flush && !r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_ld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      r_v     <= {r_v[DEPTH-2:0], w_issue};
      r_ld    <= {r_ld[DEPTH-2:0], iss_load};
      r_rd[0] <= iss_rd;
      for (int k = 1; k < DEPTH; k++) begin
        r_rd[k] <= r_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_drained <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_halted  <= r_halted || (iss_valid && iss_halt && !w_stall && !flush);
      r_drained <= r_halted && (r_v == '0);
      r_err     <= r_err || (iss_valid && r_halted) || (flush && w_stall_req);
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign fwd_a     = w_fwd_a;
  assign fwd_b     = w_fwd_b;
  assign halted    = r_halted;
  assign drained   = r_drained;
  assign stall_cnt = r_cnt;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_scoreboard : three scoreboard configurations driven by one stimulus
//                      stream, checked against an issue-history model.
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_scoreboard;

  logic       clk;
  logic       rst;
  logic       iss_valid, iss_we, iss_load, iss_use_rs, iss_use_rt, iss_halt, flush;
  logic [2:0] iss_rd, iss_rs, iss_rt;

  logic        s3, h3, d3, e3, s5, h5, d5, e5, s8, h8, d8, e8;
  logic [1:0]  fa3, fb3;
  logic [2:0]  fa5, fb5;
  logic [3:0]  fa8, fb8;
  logic [15:0] c3, c5, c8;

  pipe_scoreboard #(.DEPTH(3), .REG_W(3), .LOAD_RDY(1), .ZERO_REG(1'b0), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_we(iss_we), .iss_load(iss_load),
    .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rs(iss_use_rs),
    .iss_use_rt(iss_use_rt), .iss_halt(iss_halt), .flush(flush), .stall(s3), .fwd_a(fa3),
    .fwd_b(fb3), .halted(h3), .drained(d3), .stall_cnt(c3), .err(e3));

  pipe_scoreboard #(.DEPTH(5), .REG_W(3), .LOAD_RDY(2), .ZERO_REG(1'b1), .CNT_W(16)) u5 (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_we(iss_we), .iss_load(iss_load),
    .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rs(iss_use_rs),
    .iss_use_rt(iss_use_rt), .iss_halt(iss_halt), .flush(flush), .stall(s5), .fwd_a(fa5),
    .fwd_b(fb5), .halted(h5), .drained(d5), .stall_cnt(c5), .err(e5));

  pipe_scoreboard #(.DEPTH(8), .REG_W(3), .LOAD_RDY(7), .ZERO_REG(1'b0), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_we(iss_we), .iss_load(iss_load),
    .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rs(iss_use_rs),
    .iss_use_rt(iss_use_rt), .iss_halt(iss_halt), .flush(flush), .stall(s8), .fwd_a(fa8),
    .fwd_b(fb8), .halted(h8), .drained(d8), .stall_cnt(c8), .err(e8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // View of whichever configuration the current test targets.
  int          sel = 3;
  logic        o_stall, o_halted, o_drained, o_err;
  logic [3:0]  o_fa, o_fb;
  logic [15:0] o_cnt;

  always_comb begin
    o_stall = s3; o_fa = {2'b0, fa3}; o_fb = {2'b0, fb3};
    o_halted = h3; o_drained = d3; o_cnt = c3; o_err = e3;
    if (sel == 5) begin
      o_stall = s5; o_fa = {1'b0, fa5}; o_fb = {1'b0, fb5};
      o_halted = h5; o_drained = d5; o_cnt = c5; o_err = e5;
    end else if (sel == 8) begin
      o_stall = s8; o_fa = fa8; o_fb = fb8;
      o_halted = h8; o_drained = d8; o_cnt = c8; o_err = e8;
    end
  end

  // Reference model: a history of what entered the pipe, newest first.
  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } ent_t;

  ent_t hist[$];
  int   m_depth, m_ldrdy, m_cnt, m_total;
  bit   m_zero, m_halted, m_drained, m_err;
  bit   e_req, e_stall;
  logic [3:0]  e_fa, e_fb;
  logic [15:0] e_cnt;

  int n_chk = 0;
  int n_err = 0;

  function automatic void src_look(input logic [2:0] s, input logic use_s,
                                   output int fsel, output bit haz);
    fsel = 0;
    haz  = 1'b0;
    if (!(iss_valid && use_s) || (m_zero && s == 3'd0)) return;
    for (int age = 0; age < hist.size(); age++) begin
      if (hist[age].v && hist[age].rd == s) begin
        fsel = age + 1;
        haz  = hist[age].ld && (age < m_ldrdy);
        return;
      end
    end
  endfunction

  task automatic model_eval();
    int  fa, fb;
    bit  ha, hb;
    src_look(iss_rs, iss_use_rs, fa, ha);
    src_look(iss_rt, iss_use_rt, fb, hb);
    e_fa    = 4'(fa);
    e_fb    = 4'(fb);
    e_req   = (ha || hb) && !m_halted;
    e_stall = e_req && !flush;
    e_cnt   = 16'(m_cnt);
  endtask

  task automatic model_clock();
    bit any_v;
    bit nv;
    any_v = 1'b0;
    foreach (hist[i]) any_v |= hist[i].v;
    m_err     = m_err || (iss_valid && m_halted) || (flush && e_req);
    if (e_stall) begin
      m_total++;
      if (m_cnt < 65535) m_cnt++;
    end
    m_drained = m_halted && !any_v;
    nv = iss_valid && iss_we && !e_stall && !flush && !m_halted;
    hist.push_front(ent_t'{nv, iss_rd, iss_load});
    while (hist.size() > m_depth) void'(hist.pop_back());
    m_halted = m_halted || (iss_valid && iss_halt && !e_stall && !flush);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
    model_eval();
  endtask

  task automatic set_in(input logic v, we, ld, input logic [2:0] rd, rs, rt,
                        input logic ua, ub, h, fl);
    iss_valid = v; iss_we = we; iss_load = ld; iss_rd = rd; iss_rs = rs; iss_rt = rt;
    iss_use_rs = ua; iss_use_rt = ub; iss_halt = h; flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int which);
    sel     = which;
    m_depth = which;
    m_ldrdy = (which == 3) ? 1 : (which == 5) ? 2 : 7;
    m_zero  = (which == 5);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    m_cnt = 0; m_total = 0; m_halted = 0; m_drained = 0; m_err = 0;
    model_eval();
  endtask

  task automatic test_reset();
    do_reset(3);
    n_chk++; if ({o_stall, o_fa, o_fb, o_halted, o_drained, o_cnt, o_err} !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", {o_stall, o_fa, o_fb, o_halted, o_drained, o_cnt, o_err}); end
    set_in(1, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 3'd3, 3'd0, 3'd2, 0, 1, 0, 0);
    tick();
    n_chk++; if (o_cnt !== 16'd1) begin n_err++; $display("FAIL pre_reset_cnt got=%0d exp=1", o_cnt); end
    #3;
    rst = 1'b1;
    #1;
    n_chk++; if (o_cnt !== 16'd0 || o_fb !== 4'd0) begin n_err++; $display("FAIL async_reset got cnt=%0d fwd_b=%0d exp 0 0", o_cnt, o_fb); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(3);
    set_in(1, 1, 0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    for (int n = 1; n <= 4; n++) begin
      set_in(1, 1, 0, 3'(n + 3), 3'd1, 3'd0, 1, 0, 0, 0);
      #2;
      model_eval();
      n_chk++; if (o_fa !== 4'((n <= 3) ? n : 0) || o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_fwd_a step=%0d got fwd=%0d stall=%0d exp fwd=%0d stall=0", n, o_fa, o_stall, (n <= 3) ? n : 0); end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset(3);
    set_in(1, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 3'd3, 3'd3, 3'd2, 1, 1, 0, 0);
    #2;
    n_chk++; if (o_stall !== 1'b1 || o_fb !== 4'd1) begin n_err++; $display("FAIL lu_stall got stall=%0d fwd_b=%0d exp 1 1", o_stall, o_fb); end
    tick();
    #2;
    n_chk++; if (o_stall !== 1'b0 || o_fb !== 4'd2 || o_cnt !== 16'd1) begin n_err++; $display("FAIL lu_after got stall=%0d fwd_b=%0d cnt=%0d exp 0 2 1", o_stall, o_fb, o_cnt); end
    n_chk++; if (o_fa !== 4'd0) begin n_err++; $display("FAIL lu_bubble got fwd_a=%0d exp 0", o_fa); end
    tick();
    #2;
    n_chk++; if (o_fa !== 4'd1 || o_fb !== 4'd3) begin n_err++; $display("FAIL lu_issued got fwd_a=%0d fwd_b=%0d exp 1 3", o_fa, o_fb); end
    tick();
  endtask

  task automatic test_youngest();
    do_reset(3);
    set_in(1, 1, 0, 3'd3, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 3'd5, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 3'd3, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 3'd0, 3'd3, 3'd5, 1, 1, 0, 0);
    #2;
    n_chk++; if (o_fa !== 4'd1 || o_fb !== 4'd2) begin n_err++; $display("FAIL youngest got fwd_a=%0d fwd_b=%0d exp 1 2", o_fa, o_fb); end
    set_in(1, 0, 0, 3'd0, 3'd3, 3'd3, 1, 1, 0, 0);
    #1;
    n_chk++; if (o_fa !== 4'd1 || o_fb !== 4'd1) begin n_err++; $display("FAIL rs_eq_rt got fwd_a=%0d fwd_b=%0d exp 1 1", o_fa, o_fb); end
    tick();
    // Register 0 hardwired in the DEPTH=5 build, ordinary in the DEPTH=3 build.
    do_reset(5);
    set_in(1, 1, 1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 3'd1, 3'd0, 3'd0, 1, 1, 0, 0);
    #2;
    n_chk++; if (o_fa !== 4'd0 || o_fb !== 4'd0 || o_stall !== 1'b0) begin n_err++; $display("FAIL zero_reg got fwd_a=%0d fwd_b=%0d stall=%0d exp 0 0 0", o_fa, o_fb, o_stall); end
    n_chk++; if (fa3 !== 2'd1 || s3 !== 1'b1) begin n_err++; $display("FAIL reg0_normal got fwd_a=%0d stall=%0d exp 1 1", fa3, s3); end
    tick();
  endtask

  task automatic test_flush();
    do_reset(3);
    set_in(1, 1, 1, 3'd4, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 3'd6, 3'd4, 3'd0, 1, 0, 0, 1);
    #2;
    n_chk++; if (o_stall !== 1'b0 || o_err !== 1'b0) begin n_err++; $display("FAIL flush_stall got stall=%0d err=%0d exp 0 0", o_stall, o_err); end
    tick();
    set_in(1, 0, 0, 3'd0, 3'd6, 3'd4, 1, 1, 0, 0);
    #2;
    n_chk++; if (o_fa !== 4'd0 || o_fb !== 4'd2 || o_err !== 1'b1) begin n_err++; $display("FAIL flush_after got fwd_a=%0d fwd_b=%0d err=%0d exp 0 2 1", o_fa, o_fb, o_err); end
    tick();
  endtask

  task automatic test_halt();
    do_reset(3);
    set_in(1, 1, 0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    for (int n = 1; n <= 6; n++) begin
      if (n == 1)      set_in(1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);
      else if (n == 2) set_in(1, 1, 0, 3'd2, 3'd1, 3'd0, 1, 0, 0, 0);
      else             idle();
      #2;
      model_eval();
      n_chk++; if ({o_halted, o_drained, o_err} !== {n >= 2, n >= 5, n >= 3}) begin n_err++; $display("FAIL halt_drain cyc=%0d got h/d/e=%b%b%b exp %b%b%b", n, o_halted, o_drained, o_err, n >= 2, n >= 5, n >= 3); end
      n_chk++; if (o_fa !== e_fa) begin n_err++; $display("FAIL halt_fwd cyc=%0d got=%0d exp=%0d", n, o_fa, e_fa); end
      tick();
    end
  endtask

  task automatic test_param();
    do_reset(5);
    set_in(1, 1, 1, 3'd5, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 3'd6, 3'd5, 3'd0, 1, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      #2;
      n_chk++; if (o_stall !== (n <= 2) || o_fa !== 4'(n)) begin n_err++; $display("FAIL param_lu cyc=%0d got stall=%0d fwd_a=%0d exp %0d %0d", n, o_stall, o_fa, n <= 2, n); end
      tick();
    end
    n_chk++; if (o_cnt !== 16'd2) begin n_err++; $display("FAIL param_cnt got=%0d exp=2", o_cnt); end
  endtask

  task automatic test_random(input int which);
    do_reset(which);
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(9, 0) < 8, 1'($urandom_range(1, 0)), $urandom_range(2, 0) == 0,
             3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             (i > 250) && ($urandom_range(15, 0) == 0), $urandom_range(7, 0) == 0);
      #2;
      model_eval();
      n_chk++; if (o_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_stall, e_stall); end
      n_chk++; if (o_fa !== e_fa) begin n_err++; $display("FAIL rnd_fwd_a cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_fa, e_fa); end
      n_chk++; if (o_fb !== e_fb) begin n_err++; $display("FAIL rnd_fwd_b cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_fb, e_fb); end
      n_chk++; if (o_halted !== m_halted) begin n_err++; $display("FAIL rnd_halted cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_halted, m_halted); end
      n_chk++; if (o_drained !== m_drained) begin n_err++; $display("FAIL rnd_drained cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_drained, m_drained); end
      n_chk++; if (o_cnt !== e_cnt) begin n_err++; $display("FAIL rnd_cnt cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_cnt, e_cnt); end
      n_chk++; if (o_err !== m_err) begin n_err++; $display("FAIL rnd_err cfg=%0d i=%0d got=%0d exp=%0d", which, i, o_err, m_err); end
      tick();
    end
  endtask

  task automatic test_saturate();
    bit seen_edge;
    seen_edge = 1'b0;
    do_reset(8);
    // A load that reads its own destination re-stalls on itself indefinitely.
    set_in(1, 1, 1, 3'd5, 3'd5, 3'd0, 1, 0, 0, 0);
    for (int i = 0; i < 80000 && m_total < 65539; i++) begin
      tick();
      if (m_total == 65534 && !seen_edge) begin
        seen_edge = 1'b1;
        n_chk++; if (o_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_near got=%h exp=fffe", o_cnt); end
      end
    end
    n_chk++; if (m_total < 65539) begin n_err++; $display("FAIL sat_budget got=%0d exp>=65539 stalls", m_total); end
    n_chk++; if (o_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt got=%h exp=ffff", o_cnt); end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_flush();
    test_halt();
    test_param();
    test_random(3);
    test_random(5);
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
